// File: rtl/pe_types.sv
// Shared configuration type, accumulator FSM encoding and schedule helper
// for the packed 2x2 dot-product accumulator.
package pe_types;

  typedef struct packed {
    int unsigned dot_size;
    int unsigned mult_output_width;
  } pe_cfg_t;

  localparam pe_cfg_t PE_CFG_DEFAULT = '{dot_size: 4, mult_output_width: 9};

  typedef enum logic {
    ACC_IDLE,
    ACC_ACCUM
  } acc_state_e;

  // Cycles from a beat on the multiplier outputs to the registered result.
  function automatic int unsigned dot_latency_accum(input pe_cfg_t cfg);
    return 2 + $clog2(cfg.dot_size);
  endfunction

endpackage

// File: rtl/pe_adder_tree_pipe.sv
// Pipelined binary adder tree: N signed terms, one register per tree level,
// sum available log2(N) cycles after the terms.
module pe_adder_tree_pipe #(
  parameter int unsigned N         = 4,
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH = 24
) (
  input  logic                          clock,
  input  logic [N-1:0][IN_WIDTH-1:0]    terms,
  output logic [OUT_WIDTH-1:0]          sum
);

  // Heap layout: node i sums children 2i and 2i+1; taps N..2N-1 are the leaves.
  // With N a power of two every root-to-leaf path has the same register count.
  logic signed [OUT_WIDTH-1:0] node [1:N-1];
  logic signed [OUT_WIDTH-1:0] tap  [1:2*N-1];

  always_comb begin
    for (int unsigned i = 1; i < N; i++) begin
      tap[i] = node[i];
    end
    for (int unsigned k = 0; k < N; k++) begin
      tap[N+k] = OUT_WIDTH'($signed(terms[k]));
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 1; i < N; i++) begin
      node[i] <= tap[2*i] + tap[2*i+1];
    end
  end

  assign sum = node[1];

endmodule

// File: rtl/pe_dot_accum_4xpack.sv
// 2x2 (feature x filter) dot-product accumulator: sign-magnitude convert,
// pipelined adder tree per lane, then saturating accumulate and emit.
module pe_dot_accum_4xpack
  import pe_types::*;
#(
  parameter pe_cfg_t     cfg         = PE_CFG_DEFAULT,
  parameter int unsigned ACCUM_WIDTH = 24
) (
  input  logic                                                               clock,
  input  logic                                                               reset,
  input  logic                                                               i_valid,
  input  logic                                                               i_first,
  input  logic                                                               i_last,
  input  logic [1:0][1:0][cfg.dot_size-1:0][cfg.mult_output_width-1:0]       i_mult_output,
  output logic                                                               o_valid,
  output logic [1:0][1:0][ACCUM_WIDTH-1:0]                                   o_result,
  output logic [1:0][1:0]                                                    o_saturated
);

  localparam int unsigned N    = cfg.dot_size;
  localparam int unsigned MW   = cfg.mult_output_width;
  localparam int unsigned PIPE = dot_latency_accum(cfg) - 1;

  localparam logic [ACCUM_WIDTH-1:0] ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic [ACCUM_WIDTH-1:0] ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};

  function automatic logic [ACCUM_WIDTH-1:0] sm_to_tc(input logic [MW-1:0] p);
    logic [ACCUM_WIDTH-1:0] mag;
    mag = ACCUM_WIDTH'(p[MW-2:0]);
    return p[MW-1] ? -mag : mag;
  endfunction

  logic [1:0][1:0][N-1:0][ACCUM_WIDTH-1:0] c_data;
  logic [ACCUM_WIDTH-1:0]                  tree_sum [2][2];
  logic [PIPE-1:0]                         vld_pipe, fst_pipe, lst_pipe;
  logic                                    a_valid, a_first, a_last, emit;

  always_ff @(posedge clock) begin
    for (int unsigned f = 0; f < 2; f++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        for (int unsigned j = 0; j < N; j++) begin
          c_data[f][k][j] <= sm_to_tc(i_mult_output[f][k][j]);
        end
      end
    end
  end

  for (genvar f = 0; f < 2; f++) begin : g_feature
    for (genvar k = 0; k < 2; k++) begin : g_filter
      pe_adder_tree_pipe #(
        .N         (N),
        .IN_WIDTH  (ACCUM_WIDTH),
        .OUT_WIDTH (ACCUM_WIDTH)
      ) u_tree (
        .clock (clock),
        .terms (c_data[f][k]),
        .sum   (tree_sum[f][k])
      );
    end
  end

  // Control flags ride alongside the data through the convert and tree stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE-2:0], i_valid};
      fst_pipe <= {fst_pipe[PIPE-2:0], i_first};
      lst_pipe <= {lst_pipe[PIPE-2:0], i_last};
    end
  end

  assign a_valid = vld_pipe[PIPE-1];
  assign a_first = fst_pipe[PIPE-1];
  assign a_last  = lst_pipe[PIPE-1];

  acc_state_e state_q, state_d;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ACC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (a_valid) begin
      if (a_last)       state_d = ACC_IDLE;
      else if (a_first) state_d = ACC_ACCUM;
    end
  end

  logic [1:0][1:0][ACCUM_WIDTH-1:0] acc_q, acc_d;
  logic [1:0][1:0]                  sticky_q, sticky_d;

  // A beat without first always continues from the held accumulator,
  // whether or not the FSM is currently in ACCUM.
  always_comb begin
    logic [ACCUM_WIDTH-1:0] base;
    logic [ACCUM_WIDTH:0]   wide;
    logic                   clip;
    base     = '0;
    wide     = '0;
    clip     = 1'b0;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    emit     = a_valid & a_last;
    for (int unsigned f = 0; f < 2; f++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        base = a_first ? '0 : acc_q[f][k];
        wide = {base[ACCUM_WIDTH-1], base}
             + {tree_sum[f][k][ACCUM_WIDTH-1], tree_sum[f][k]};
        clip = wide[ACCUM_WIDTH] ^ wide[ACCUM_WIDTH-1];
        if (a_valid) begin
          acc_d[f][k]    = clip ? (wide[ACCUM_WIDTH] ? ACC_MIN : ACC_MAX)
                                : wide[ACCUM_WIDTH-1:0];
          sticky_d[f][k] = (a_first ? 1'b0 : sticky_q[f][k]) | clip;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      sticky_q    <= '0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_saturated <= '0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      o_valid  <= emit;
      if (emit) begin
        o_result    <= acc_d;
        o_saturated <= sticky_d;
      end
    end
  end

endmodule

// File: tb/tb_pe_dot_accum_4xpack.sv
// Bench for pe_dot_accum_4xpack: two widths (24 and 12) share stimulus,
// checked every cycle against a delay-line + arithmetic reference.
module tb_pe_dot_accum_4xpack;
  import pe_types::*;

  localparam pe_cfg_t CFG = '{dot_size: 4, mult_output_width: 9};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0;
  logic [1:0][1:0][3:0][8:0] mult = '0;

  logic                    v24, v12;
  logic [1:0][1:0][23:0]   r24;
  logic [1:0][1:0][11:0]   r12;
  logic [1:0][1:0]         s24, s12;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pe_dot_accum_4xpack #(.cfg(CFG), .ACCUM_WIDTH(24)) u_dut24 (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_first(i_first),
    .i_last(i_last), .i_mult_output(mult), .o_valid(v24), .o_result(r24),
    .o_saturated(s24)
  );

  pe_dot_accum_4xpack #(.cfg(CFG), .ACCUM_WIDTH(12)) u_dut12 (
    .clock(clock), .reset(reset), .i_valid(i_valid), .i_first(i_first),
    .i_last(i_last), .i_mult_output(mult), .o_valid(v12), .o_result(r12),
    .o_saturated(s12)
  );

  typedef struct {
    bit v;
    bit f;
    bit l;
    logic [1:0][1:0][3:0][8:0] d;
  } beat_t;

  typedef struct {
    longint acc;
    bit     st;
  } lane_t;

  beat_t hist [3];
  lane_t m [2][4];
  lane_t e [2][4];
  bit    e_val [2];
  bit    started = 1'b0;

  function automatic int aw(input int i);
    return (i == 0) ? 24 : 12;
  endfunction

  function automatic longint lane_sum(input logic [3:0][8:0] p);
    longint s = 0;
    for (int j = 0; j < 4; j++) begin
      if (p[j][8]) s -= longint'(p[j][7:0]);
      else         s += longint'(p[j][7:0]);
    end
    return s;
  endfunction

  function automatic lane_t step(input lane_t cur, input bit first, input longint s, input int w);
    lane_t  n;
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    longint mn = -mx - 1;
    n.acc = first ? s : cur.acc + s;
    n.st  = first ? 1'b0 : cur.st;
    if (n.acc > mx) begin n.acc = mx; n.st = 1'b1; end
    else if (n.acc < mn) begin n.acc = mn; n.st = 1'b1; end
    return n;
  endfunction

  function automatic void chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference: a beat reaches the accumulator three edges after it is sampled.
  always @(posedge clock) begin
    started <= 1'b1;
    if (reset) begin
      for (int i = 0; i < 3; i++) hist[i] <= '{v: 1'b0, f: 1'b0, l: 1'b0, d: '0};
      for (int i = 0; i < 2; i++) begin
        e_val[i] <= 1'b0;
        for (int ln = 0; ln < 4; ln++) begin
          m[i][ln] <= '{acc: 0, st: 1'b0};
          e[i][ln] <= '{acc: 0, st: 1'b0};
        end
      end
    end else begin
      hist[0] <= '{v: i_valid, f: i_first, l: i_last, d: mult};
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      for (int i = 0; i < 2; i++) begin
        e_val[i] <= hist[2].v && hist[2].l;
        if (hist[2].v) begin
          for (int ln = 0; ln < 4; ln++) begin
            m[i][ln] <= step(m[i][ln], hist[2].f, lane_sum(hist[2].d[ln/2][ln%2]), aw(i));
            if (hist[2].l)
              e[i][ln] <= step(m[i][ln], hist[2].f, lane_sum(hist[2].d[ln/2][ln%2]), aw(i));
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("o_valid aw24", longint'(v24), longint'(e_val[0]));
      chk("o_valid aw12", longint'(v12), longint'(e_val[1]));
      for (int ln = 0; ln < 4; ln++) begin
        chk($sformatf("o_result[%0d][%0d] aw24", ln/2, ln%2),
            longint'($signed(r24[ln/2][ln%2])), e[0][ln].acc);
        chk($sformatf("o_result[%0d][%0d] aw12", ln/2, ln%2),
            longint'($signed(r12[ln/2][ln%2])), e[1][ln].acc);
        chk($sformatf("o_saturated[%0d][%0d] aw24", ln/2, ln%2),
            longint'(s24[ln/2][ln%2]), longint'(e[0][ln].st));
        chk($sformatf("o_saturated[%0d][%0d] aw12", ln/2, ln%2),
            longint'(s12[ln/2][ln%2]), longint'(e[1][ln].st));
      end
    end
  end

  task automatic drive_arr(input bit v, input bit fst, input bit lst,
                           input logic [1:0][1:0][3:0][8:0] arr);
    @(negedge clock);
    i_valid = v;
    i_first = fst;
    i_last  = lst;
    mult    = arr;
  endtask

  task automatic drive(input bit v, input bit fst, input bit lst, input logic [3:0][8:0] dot);
    logic [1:0][1:0][3:0][8:0] arr;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) arr[a][b] = dot;
    drive_arr(v, fst, lst, arr);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Literal expectations pin both the DUT and the reference model.
  task automatic lit_all(input string name, input int inst, input longint val, input bit sat);
    for (int ln = 0; ln < 4; ln++) begin
      if (inst == 0) begin
        chk({name, " dut24"}, longint'($signed(r24[ln/2][ln%2])), val);
        chk({name, " sat24"}, longint'(s24[ln/2][ln%2]), longint'(sat));
      end else begin
        chk({name, " dut12"}, longint'($signed(r12[ln/2][ln%2])), val);
        chk({name, " sat12"}, longint'(s12[ln/2][ln%2]), longint'(sat));
      end
      chk({name, " model"}, e[inst][ln].acc, val);
    end
  endtask

  initial begin
    logic [1:0][1:0][3:0][8:0] arr;
    logic [3:0][8:0] d10, d7, d2, d1, d5, dff, d001;
    bit bias;
    d10  = {9'd4, 9'd3, 9'd2, 9'd1};
    d7   = {9'd0, 9'd4, 9'd2, 9'd1};
    d2   = {9'd0, 9'd0, 9'd1, 9'd1};
    d1   = {9'd0, 9'd0, 9'd0, 9'd1};
    d5   = {9'd0, 9'd0, 9'd0, 9'd5};
    dff  = {4{9'h0FF}};
    d001 = {4{9'h001}};

    // A beat offered while reset is held must vanish.
    drive(1'b1, 1'b1, 1'b1, dff);
    idle(2);
    @(negedge clock);
    reset = 1'b0;
    chk("reset o_valid", longint'(v24), 0);
    lit_all("reset o_result", 0, 0, 1'b0);

    drive(1'b1, 1'b1, 1'b1, dff);
    idle(3);
    chk("latency early o_valid", longint'(v24), 0);
    idle(1);
    chk("all 0x0FF o_valid", longint'(v24), 1);
    lit_all("all 0x0FF", 0, 1020, 1'b0);

    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) arr[a][b] = {4{9'h100}};
    arr[1][0] = {4{9'h103}};
    drive_arr(1'b1, 1'b1, 1'b1, arr);
    idle(4);
    chk("neg lane[1][0]", longint'($signed(r24[1][0])), -12);
    chk("neg-zero lane[0][0]", longint'($signed(r24[0][0])), 0);
    chk("neg-zero lane[1][1]", longint'($signed(r24[1][1])), 0);

    drive(1'b1, 1'b1, 1'b0, d10);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, d10);
    idle(1);
    drive(1'b1, 1'b0, 1'b1, d10);
    idle(3);
    chk("3-beat early o_valid", longint'(v24), 0);
    idle(1);
    chk("3-beat o_valid", longint'(v24), 1);
    lit_all("3-beat sum", 0, 30, 1'b0);

    drive(1'b1, 1'b1, 1'b0, dff);
    drive(1'b1, 1'b0, 1'b0, dff);
    drive(1'b1, 1'b0, 1'b1, dff);
    idle(4);
    lit_all("clip aw12", 1, 2047, 1'b1);
    lit_all("noclip aw24", 0, 3060, 1'b0);
    drive(1'b1, 1'b1, 1'b1, d001);
    idle(4);
    lit_all("reload aw12", 1, 4, 1'b0);

    drive(1'b1, 1'b1, 1'b0, d10);
    idle(1);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, d10);
    @(negedge clock);
    reset = 1'b0;
    i_valid = 1'b0;
    i_first = 1'b0;
    i_last  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      idle(1);
      chk("dropped beat o_valid", longint'(v24), 0);
    end
    drive(1'b1, 1'b1, 1'b1, d5);
    idle(4);
    lit_all("after reset", 0, 5, 1'b0);

    drive(1'b1, 1'b1, 1'b0, d7);
    drive(1'b1, 1'b1, 1'b0, d2);
    drive(1'b1, 1'b0, 1'b1, d1);
    idle(4);
    lit_all("restart first", 0, 3, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset   = ($urandom_range(0, 199) == 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_first = ($urandom_range(0, 4) == 0);
      i_last  = ($urandom_range(0, 4) == 0);
      bias    = 1'($urandom_range(0, 1));
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++)
          for (int j = 0; j < 4; j++)
            mult[a][b][j] = {bias ? 1'b0 : 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))};
    end
    @(negedge clock);
    reset = 1'b0;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_dot_accum_4xpack.md
PE_DOT_ACCUM_4XPACK -- requirements
Module: pe_dot_accum_4xpack

Interface
REQ-001 cfg, none (pe_cfg_t), supplies DOT_SIZE (even, power of 2) and MULT_OUTPUT_WIDTH (sign bit + magnitude).
REQ-002 ACCUM_WIDTH, 24, signed two's-complement width of each accumulated result; SHALL be >= MULT_OUTPUT_WIDTH + log2(DOT_SIZE).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  products on i_mult_output are valid this cycle (already aligned to multiplier latency).
REQ-006 i_first  input  1  qualified by i_valid; beat starts a new accumulation.
REQ-007 i_last  input  1  qualified by i_valid; beat ends the accumulation, result emitted.
REQ-008 i_mult_output  input  [2][2][DOT_SIZE][MULT_OUTPUT_WIDTH]  sign-magnitude products [feature][filter][dot idx], MSB = sign.
REQ-009 o_valid  output  1  one-cycle pulse, o_result holds a completed accumulation.
REQ-010 o_result  output  [2][2][ACCUM_WIDTH]  signed dot-product accumulations [feature][filter].
REQ-011 o_saturated  output  [2][2]  per-lane flag, lane clipped during the emitted accumulation; valid with o_valid.

Function
REQ-012 Stage C (1 cycle): each product SHALL be converted sign-magnitude -> two's complement, sign-extended to ACCUM_WIDTH; sign=1 with magnitude 0 SHALL yield 0.
REQ-013 Stage T (log2(DOT_SIZE) cycles): per lane, pipelined binary adder tree summing DOT_SIZE terms, one register per tree level; full precision, no truncation.
REQ-014 Stage A (1 cycle): per-lane accumulator.
REQ-015 Latency i_valid&i_last -> o_valid SHALL be exactly 2 + log2(DOT_SIZE) cycles; throughput one beat per cycle, no back-pressure.
REQ-016 i_valid, i_first, i_last SHALL travel with data through C and T in a side pipeline of equal depth.
REQ-017 Accumulator FSM states IDLE, ACCUM; IDLE->ACCUM on valid beat with first and not last; ACCUM->IDLE on valid beat with last; first&last on one beat stays/returns IDLE and emits.
REQ-018 Valid beat with first: acc <= tree sum (previous partial discarded, even if in ACCUM).
REQ-019 Valid beat without first: acc <= acc + tree sum, including a beat arriving in IDLE (continues from current acc).
REQ-020 Invalid beat (bubble): acc, FSM, outputs unchanged; o_valid = 0.
REQ-021 Addition SHALL saturate to [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1]; lane sticky saturation flag set on clip, cleared by first-beat load (then set only if that load clips).
REQ-022 On last beat: o_result <= saturated new acc, o_saturated <= new sticky flags, o_valid <= 1 next cycle; o_result/o_saturated hold until the next emission.

Reset
REQ-023 reset SHALL clear all pipeline valid bits, acc, sticky flags, o_result, o_saturated, o_valid to 0 and force FSM to IDLE on the next edge.
REQ-024 Beats in flight at reset SHALL be dropped; no o_valid for them; a beat presented during reset SHALL be ignored.
REQ-025 Data pipeline registers need not be reset; only control and outputs.

Structure
REQ-026 pe_types SHALL hold pe_cfg_t and a function returning DOT_LATENCY_ACCUM = 2 + clog2(DOT_SIZE) for schedule alignment.
REQ-027 The per-lane pipelined tree SHALL be sub-module pe_adder_tree_pipe (params N, IN_WIDTH, OUT_WIDTH), instantiated four times.

Verification (DOT_SIZE=4, MULT_OUTPUT_WIDTH=9, ACCUM_WIDTH=24, latency 4)
REQ-028 Single beat first&last, all products 0x0FF -> 4 cycles later o_valid=1, all o_result=1020, o_saturated=0.
REQ-029 Single beat first&last, lane[1][0] products 0x103 (-3), others 0x100 (-0) -> o_result[1][0]=-12, other lanes 0.
REQ-030 Three beats (first, bubble, mid, bubble, last), each lane sum 10 -> one o_valid pulse, o_result=30, 4 cycles after last beat.
REQ-031 ACCUM_WIDTH=12, three beats of 0x0FF on all products -> o_result=2047, o_saturated=1 all lanes; following first&last beat of 0x001 -> 4, o_saturated=0.
REQ-032 first at cycle 0, reset at cycle 2, last at cycle 3 -> no o_valid; then first&last sum 5 -> o_result=5 (no residue).
REQ-033 first beat (sum 7) then new first beat (sum 2) then last beat (sum 1) -> o_result=3.
